// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encodings, unit values, FSM states and default widths.
// Used by both the coin-accept controller and the change dispenser.
package vend_pkg;

   localparam int UNIT_W_DEF = 4;

   localparam logic [1:0] COIN_5  = 2'b00;
   localparam logic [1:0] COIN_10 = 2'b01;
   localparam logic [1:0] COIN_25 = 2'b10;

   // Coin values expressed in 5-cent units
   localparam int unsigned UNIT_5  = 1;
   localparam int unsigned UNIT_10 = 2;
   localparam int unsigned UNIT_25 = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      REQ    = 2'd2,
      FINISH = 2'd3
   } state_e;

   function automatic int unsigned coin_value(input logic [1:0] t);
      case (t)
         COIN_25: return UNIT_25;
         COIN_10: return UNIT_10;
         default: return UNIT_5;
      endcase
   endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Change-dispenser bus: transaction request/result plus per-coin hopper handshake.
interface vend_change_dispenser_if
   import vend_pkg::*;
   #(parameter int UNIT_W = UNIT_W_DEF) ();

   logic              start;
   logic [UNIT_W-1:0] change_units;
   logic [2:0]        hopper_empty;
   logic              coin_ack;
   logic              coin_req;
   logic [1:0]        coin_type;
   logic              busy;
   logic              done;
   logic [UNIT_W-1:0] short_units;

   modport master (
      output start, change_units, hopper_empty, coin_ack,
      input  coin_req, coin_type, busy, done, short_units
   );

   modport slave (
      input  start, change_units, hopper_empty, coin_ack,
      output coin_req, coin_type, busy, done, short_units
   );

endinterface

// File: rtl/vend_coin_select.sv
// Combinational greedy selector: largest coin that fits, is stocked and has not failed.
module vend_coin_select
   import vend_pkg::*;
#(
   parameter int UNIT_W = UNIT_W_DEF
) (
   input  logic [UNIT_W-1:0] remaining_i,
   input  logic [2:0]        hopper_empty_i,
   input  logic [2:0]        fail_i,
   output logic              found_o,
   output logic [1:0]        coin_type_o
);

   always_comb begin
      found_o     = 1'b0;
      coin_type_o = COIN_5;
      if (!hopper_empty_i[2] && !fail_i[2] && remaining_i >= UNIT_W'(UNIT_25)) begin
         found_o     = 1'b1;
         coin_type_o = COIN_25;
      end else if (!hopper_empty_i[1] && !fail_i[1] && remaining_i >= UNIT_W'(UNIT_10)) begin
         found_o     = 1'b1;
         coin_type_o = COIN_10;
      end else if (!hopper_empty_i[0] && !fail_i[0] && remaining_i >= UNIT_W'(UNIT_5)) begin
         found_o     = 1'b1;
         coin_type_o = COIN_5;
      end
   end

endmodule

// File: rtl/vend_change_dispenser.sv
// Pays a change amount out coin-by-coin through a req/ack hopper handshake,
// falling back to smaller coins on empty or unresponsive tubes and reporting any shortfall.
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16,
   parameter int UNIT_W      = UNIT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   vend_change_dispenser_if.slave  bus
);

   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   state_e            state_q, state_d;
   logic [UNIT_W-1:0] remaining_q, remaining_d;
   logic [UNIT_W-1:0] short_q, short_d;
   logic [2:0]        fail_q, fail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic [1:0]        type_q, type_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              sel_found;
   logic [1:0]        sel_type;

   vend_coin_select #(.UNIT_W(UNIT_W)) u_select (
      .remaining_i    (remaining_q),
      .hopper_empty_i (bus.hopper_empty),
      .fail_i         (fail_q),
      .found_o        (sel_found),
      .coin_type_o    (sel_type)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         short_q     <= '0;
         fail_q      <= '0;
         cnt_q       <= '0;
         req_q       <= 1'b0;
         type_q      <= COIN_5;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         short_q     <= short_d;
         fail_q      <= fail_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         type_q      <= type_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      short_d     = short_q;
      fail_d      = fail_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      type_d      = type_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               remaining_d = bus.change_units;
               fail_d      = '0;
               short_d     = '0;
               busy_d      = 1'b1;
               state_d     = SELECT;
            end
         end
         SELECT: begin
            // Shortfall is registered here so it is already valid in the done cycle
            if (sel_found) begin
               type_d  = sel_type;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = REQ;
            end else begin
               short_d = remaining_q;
               done_d  = 1'b1;
               state_d = FINISH;
            end
         end
         REQ: begin
            if (bus.coin_ack) begin
               remaining_d = remaining_q - UNIT_W'(coin_value(type_q));
               req_d       = 1'b0;
               state_d     = SELECT;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               fail_d  = fail_q | (3'b001 << type_q);
               req_d   = 1'b0;
               state_d = SELECT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.coin_req    = req_q;
   assign bus.coin_type   = type_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.short_units = short_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Randomized bench for the change dispenser against a greedy payout reference model.
module tb_vend_change_dispenser;
   import vend_pkg::*;

   localparam int ACK_TIMEOUT = 16;
   localparam int UNIT_W      = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   vend_change_dispenser_if #(.UNIT_W(UNIT_W)) bus ();

   vend_change_dispenser #(.ACK_TIMEOUT(ACK_TIMEOUT), .UNIT_W(UNIT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference: walk denominations largest-first; a dead tube costs one attempt then is skipped.
   task automatic model(input int chg, input logic [2:0] emp, input logic [2:0] dead,
                        output int seq[$], output int short_u);
      int vals[3] = '{1, 2, 5};
      bit failed[3] = '{0, 0, 0};
      int rem = chg;
      bit progress = 1;
      seq.delete();
      while (progress) begin
         progress = 0;
         for (int d = 2; d >= 0; d--) begin
            if (!emp[d] && !failed[d] && vals[d] <= rem) begin
               seq.push_back(d);
               if (dead[d]) failed[d] = 1;
               else rem -= vals[d];
               progress = 1;
               break;
            end
         end
      end
      short_u = rem;
   endtask

   task automatic run_txn(input int chg, input logic [2:0] emp, input logic [2:0] dead,
                          input int dly_lo, input int dly_hi, input bit poke);
      int exp_q[$];
      int obs_q[$];
      int exp_short, cyc, req_len, dly, cur_t, first_req, unstable;
      bit got_done, prev_req, poked;
      model(chg, emp, dead, exp_q, exp_short);
      @(negedge clk);
      bus.start        = 1'b1;
      bus.change_units = UNIT_W'(chg);
      bus.hopper_empty = emp;
      @(negedge clk);
      bus.start        = 1'b0;
      bus.change_units = ~UNIT_W'(chg);
      chk("busy_after_start", bus.busy, 1);
      chk("short_cleared", bus.short_units, 0);
      cyc = 0; got_done = 0; prev_req = 0; poked = 0; req_len = 0; dly = 0;
      cur_t = 0; first_req = -1; unstable = 0;
      while (!got_done && cyc < 1500) begin
         bus.start = 1'b0;
         if (bus.done) begin
            got_done = 1;
            if (exp_q.size() == 0) chk("done_latency", cyc, 1);
            chk("short_units", bus.short_units, exp_short);
            chk("req_low_at_done", bus.coin_req, 0);
         end
         if (bus.coin_req) begin
            if (!prev_req) begin
               cur_t = int'(bus.coin_type);
               obs_q.push_back(cur_t);
               req_len = 0;
               dly = $urandom_range(dly_hi, dly_lo);
               if (first_req < 0) first_req = cyc;
            end else if (int'(bus.coin_type) != cur_t) unstable++;
            req_len++;
            bus.coin_ack = (cur_t < 3 && !dead[cur_t] && req_len > dly);
            if (poke && !poked) begin
               bus.start = 1'b1;
               poked = 1;
            end
         end else begin
            if (prev_req && cur_t < 3 && dead[cur_t])
               chk("timeout_len", req_len, ACK_TIMEOUT);
            bus.coin_ack = 1'($urandom_range(1, 0));
         end
         prev_req = bus.coin_req;
         @(negedge clk);
         cyc++;
      end
      bus.coin_ack = 1'b0;
      bus.start    = 1'b0;
      chk("done_seen", got_done, 1);
      chk("type_stable", unstable, 0);
      if (exp_q.size() != 0) chk("first_req_latency", first_req, 1);
      chk("coin_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk("coin_type_seq", obs_q[i], exp_q[i]);
      chk("done_one_cycle", bus.done, 0);
      chk("busy_low_after", bus.busy, 0);
      @(negedge clk);
      chk("short_held", bus.short_units, exp_short);
   endtask

   initial begin
      int seen_done;
      bus.start        = 1'b0;
      bus.change_units = '0;
      bus.hopper_empty = 3'b000;
      bus.coin_ack     = 1'b0;
      #1;
      chk("rst_coin_req", bus.coin_req, 0);
      chk("rst_coin_type", bus.coin_type, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_short", bus.short_units, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_txn(8, 3'b000, 3'b000, 1, 1, 0);
      run_txn(4, 3'b010, 3'b000, 0, 2, 0);
      run_txn(7, 3'b000, 3'b100, 0, 1, 0);
      run_txn(3, 3'b011, 3'b000, 0, 0, 0);
      run_txn(0, 3'b000, 3'b000, 0, 0, 0);
      run_txn(9, 3'b000, 3'b000, 2, 3, 1);
      run_txn(15, 3'b001, 3'b010, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [2:0] emp, dead;
         emp  = 3'($urandom_range(7, 0));
         dead = {($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0)};
         run_txn(int'($urandom_range(15, 0)), emp, dead, 0, 3, n[0]);
      end

      // Reset in the middle of a coin request
      @(negedge clk);
      bus.start = 1'b1; bus.change_units = 4'd6; bus.hopper_empty = 3'b000;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 10 && !bus.coin_req; i++) @(negedge clk);
      chk("req_before_rst", bus.coin_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_req", bus.coin_req, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_done", bus.done, 0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done || bus.coin_req || bus.busy) seen_done++;
      end
      chk("no_activity_after_rst", seen_done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
